// File: rtl/seq_det_prog.sv
// rtl/seq_det_prog.sv - programmable serial sequence detector, Mealy flag, optional match counter (SEQ_DET_PROG_CNT_EN)
module seq_det_prog #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap,
    input  logic               seq_valid,
    input  logic               seq_in,
    input  logic               cnt_clr,
    output logic               flag,
    output logic [CNT_W-1:0]   match_cnt
);

    logic [MAX_LEN-1:0] cfg_pat;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_ovl;
    logic [MAX_LEN-2:0] hist;
    logic [LEN_W-1:0]   fill;

    logic [LEN_W-1:0]   eff_len;
    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] len_mask;
    logic               len_ok;
    logic               bits_ok;
    logic               accept;
    logic [LEN_W-1:0]   fill_next;

    // Clamp the programmed length and build the mask of compared window bits
    always_comb begin
        eff_len  = cfg_len;
        len_mask = '0;
        if (cfg_len > LEN_W'(MAX_LEN)) begin
            eff_len = LEN_W'(MAX_LEN);
        end
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < 32'(eff_len));
        end
    end

    // Compare the newest L bits against the pattern and raise the Mealy flag
    always_comb begin
        window  = {hist, seq_in};
        accept  = seq_valid & ~cfg_load;
        len_ok  = ((LEN_W+1)'(fill) + (LEN_W+1)'(1)) >= (LEN_W+1)'(eff_len);
        bits_ok = (((window ^ cfg_pat) & len_mask) == '0);
        flag    = accept & (eff_len != '0) & len_ok & bits_ok;
    end

    // Fill count: saturates at MAX_LEN, restarts after a match in non-overlap mode
    always_comb begin
        fill_next = fill;
        if (flag && !cfg_ovl) begin
            fill_next = '0;
        end else if (fill != LEN_W'(MAX_LEN)) begin
            fill_next = fill + 1'b1;
        end
    end

    // Configuration and history registers; a load discards that cycle's bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_pat <= '0;
            cfg_len <= '0;
            cfg_ovl <= 1'b1;
            hist    <= '0;
            fill    <= '0;
        end else if (cfg_load) begin
            cfg_pat <= pattern;
            cfg_len <= pat_len;
            cfg_ovl <= overlap;
            fill    <= '0;
        end else if (seq_valid) begin
            hist    <= window[MAX_LEN-2:0];
            fill    <= fill_next;
        end
    end

`ifdef SEQ_DET_PROG_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating match counter; a clear in a matching cycle leaves one count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= CNT_W'(flag);
        end else if (flag && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign match_cnt = cnt_q;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_det_prog.sv
// tb/tb_seq_det_prog.sv - directed self-checking bench for seq_det_prog
module tb_seq_det_prog;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 2;

`ifdef SEQ_DET_PROG_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic               clk       = 1'b0;
    logic               rst_n     = 1'b0;
    logic               cfg_load  = 1'b0;
    logic [MAX_LEN-1:0] pattern   = '0;
    logic [LEN_W-1:0]   pat_len   = '0;
    logic               overlap   = 1'b1;
    logic               seq_valid = 1'b0;
    logic               seq_in    = 1'b0;
    logic               cnt_clr   = 1'b0;
    logic               flag;
    logic [CNT_W-1:0]   match_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    seq_det_prog #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_load  (cfg_load),
        .pattern   (pattern),
        .pat_len   (pat_len),
        .overlap   (overlap),
        .seq_valid (seq_valid),
        .seq_in    (seq_in),
        .cnt_clr   (cnt_clr),
        .flag      (flag),
        .match_cnt (match_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_cnt(input string tag, input int n);
        check(tag, 32'(match_cnt), CNT_ON ? 32'(n) : 32'd0);
    endtask

    task automatic step(input logic v, input logic b, input logic ld, input logic clr,
                        input logic ef, input string tag);
        seq_valid = v;
        seq_in    = b;
        cfg_load  = ld;
        cnt_clr   = clr;
        #1;
        check(tag, 32'(flag), 32'(ef));
        @(posedge clk);
        #1;
        seq_valid = 1'b0;
        cfg_load  = 1'b0;
        cnt_clr   = 1'b0;
    endtask

    task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input logic o);
        pattern = p;
        pat_len = l;
        overlap = o;
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "load_flag");
    endtask

    task automatic send(input logic [15:0] bits, input int n, input logic [15:0] flags, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, bits[i], 1'b0, 1'b0, flags[i], $sformatf("%s_%0d", tag, n - i));
        end
    endtask

    task automatic clear_cnt();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "clr_flag");
        check_cnt("clr_cnt", 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        seq_valid = 1'b1;
        seq_in    = 1'b1;
        #1;
        check("rst_flag", 32'(flag), 32'd0);
        check_cnt("rst_cnt", 0);
        seq_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        load(8'h5A, 4'd7, 1'b1);
        send(16'b101, 3, 16'b0, "pre_rst");
        @(negedge clk);
        rst_n     = 1'b0;
        seq_valid = 1'b1;
        seq_in    = 1'b0;
        #1;
        check("mid_rst_flag", 32'(flag), 32'd0);
        check_cnt("mid_rst_cnt", 0);
        seq_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(16'b1011010, 7, 16'b0, "post_rst");

        load(8'h5A, 4'd7, 1'b1);
        send(16'b101101011010, 12, 16'b000000100001, "ovl");
        check_cnt("ovl_cnt", 2);
        clear_cnt();

        load(8'h5A, 4'd7, 1'b0);
        send(16'b101101011010, 12, 16'b000000100000, "novl");
        check_cnt("novl_cnt", 1);
        clear_cnt();

        load(8'h5A, 4'd7, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "gap_1");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "gap_2");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "gap_b1");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "gap_3");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "gap_4");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "gap_b2");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "gap_b3");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "gap_5");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "gap_6");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "gap_7");

        send(16'b101101, 6, 16'b0, "pri");
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "pri_last");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "fill_clr");
        send(16'b1011010, 7, 16'b0000001, "after");
        check_cnt("gap_cnt", 2);
        clear_cnt();

        load(8'hF1, 4'd1, 1'b1);
        send(16'b0110, 4, 16'b0110, "len1");
        check_cnt("len1_cnt", 2);
        clear_cnt();

        load(8'hFF, 4'd8, 1'b1);
        send(16'hFFF, 12, 16'b000000011111, "len8");
        check_cnt("sat_cnt", 3);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "clr_hit");
        check_cnt("clr_hit_cnt", 1);

        load(8'hFF, 4'd0, 1'b1);
        send(16'h1F, 5, 16'b0, "len0");
        check_cnt("len0_cnt", 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seq_det_prog.md
# seq_det_prog

Programmable serial sequence detector: the next generation of the fixed-pattern Mealy detector, generalised to any pattern of 1..MAX_LEN bits loaded at run time. It supports overlapping and non-overlapping match modes, a valid-qualified input stream and an optional saturating match counter. It sits on a serial bit stream (after a deserialiser or sampler) and raises a same-cycle Mealy flag when the last received bits equal the loaded pattern.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (2..32).
- LEN_W, 4: width of pat_len; must satisfy 2^LEN_W > MAX_LEN.
- CNT_W, 8: width of match_cnt.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_load  in  1  latch pattern, pat_len and overlap; clear history.
- pattern  in  MAX_LEN  pattern; bit [pat_len-1] is the first bit received, bit [0] the last.
- pat_len  in  LEN_W  pattern length.
- overlap  in  1  1 = overlapping matches allowed; 0 = history is cleared after each match.
- seq_valid  in  1  seq_in is valid this cycle.
- seq_in  in  1  serial data bit.
- cnt_clr  in  1  synchronous clear of match_cnt (macro-dependent).
- flag  out  1  Mealy match indication, combinational.
- match_cnt  out  CNT_W  number of matches (macro-dependent).

## Operation
- Registers: cfg_pat[MAX_LEN], cfg_len[LEN_W], cfg_ovl, hist[MAX_LEN-1] (shift register of past valid bits), fill[LEN_W] (number of valid bits held, saturating at MAX_LEN).
- Reset values: cfg_pat = 0, cfg_len = 0, cfg_ovl = 1, hist = 0, fill = 0, match_cnt = 0.
- Effective length L = min(cfg_len, MAX_LEN). L = 0 disables detection: flag stays 0 and history still shifts.
- Candidate window w = {hist, seq_in}; flag = seq_valid & ~cfg_load & (L != 0) & (fill + 1 >= L) & (low L bits of w == low L bits of cfg_pat).
- On a valid bit with no cfg_load: hist <= w[MAX_LEN-2:0]; fill <= min(fill + 1, MAX_LEN).
- On a match with cfg_ovl = 0: fill <= 0 instead of incrementing. hist still shifts, but the cleared fill masks it.
- cfg_load takes priority over seq_valid in the same cycle:
  - cfg_pat, cfg_len and cfg_ovl are loaded; fill <= 0.
  - The seq_in bit that cycle is discarded and flag = 0.
- When seq_valid = 0: hist and fill hold, and flag = 0.
- Pattern bits above L are don't-care.
- A reset asserted mid-stream returns all registers to their reset values immediately. Detection is then disabled until the next cfg_load.

## Timing
- flag is combinational from seq_in, seq_valid and the registered state, in the same cycle the final pattern bit is presented (zero latency, Mealy).
- Register updates take effect on the rising clk edge.
- The first bit after a cfg_load is accepted on the following cycle.
- The minimum gap between overlapping matches is 1 cycle (e.g. pattern "11").

## Configuration
- SEQ_DET_PROG_CNT_EN defined:
  - match_cnt increments on each cycle with flag = 1 and saturates at all-ones.
  - cnt_clr clears it; when cnt_clr and flag occur in the same cycle, the result is 1.
  - cfg_load does not clear it.
- SEQ_DET_PROG_CNT_EN undefined: the counter logic is removed, match_cnt is tied to 0 and cnt_clr is ignored.

## Test plan
- Reset: assert rst_n = 0 mid-stream -> flag = 0 and match_cnt = 0; with no cfg_load afterwards, stream 1011010 -> flag stays 0.
- Overlap mode: load pattern 1011010, L = 7, overlap = 1; send 1011010 then 11010 -> flag on valid bits 7 and 12; match_cnt = 2.
- Non-overlap mode: same pattern and stream with overlap = 0 -> flag on bit 7 only; match_cnt = 1.
- Valid gaps and priority:
  - Insert seq_valid = 0 bubbles inside the pattern -> match still detected on the last valid bit.
  - Assert cfg_load on the last bit -> flag = 0 and fill = 0.
- Length edges:
  - L = 1, pattern 1; stream 0110 -> flag on bits 2 and 3.
  - L = MAX_LEN, all-ones stream -> first flag on bit 8, then every bit.
  - pat_len = 0 -> flag never asserts.
- Counter (macro on): CNT_W = 2, 5 matches -> match_cnt = 3 (saturated). cnt_clr together with a match -> match_cnt = 1. Macro off -> match_cnt = 0 throughout.
